// File: rtl/id_stage_pipe.sv
// RV32I + Zicsr/ecall instruction decode stage with operand forwarding,
// branch compare, load-use interlock and a registered ID/EX handshake stage.
module id_stage_pipe #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter bit CSR_EN         = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            fwd_ex_we,
  input  logic            fwd_ex_is_load,
  input  logic [4:0]      fwd_ex_addr,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_addr,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_addr,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [18:0]     out_exe_fun,
  output logic            out_mem_we,
  output logic            out_mem_re,
  output logic [2:0]      out_wb_sel,
  output logic [3:0]      out_csr_cmd,
  output logic [11:0]     out_csr_addr,
  output logic            out_illegal,
  output logic            hazard_stall
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam int F_ADD  = 18, F_SUB  = 17, F_AND  = 16, F_OR   = 15, F_XOR = 14;
  localparam int F_SLL  = 13, F_SRL  = 12, F_SRA  = 11, F_SLT  = 10, F_SLTU = 9;
  localparam int F_BEQ  = 8,  F_BNE  = 7,  F_BGE  = 6,  F_BGEU = 5,  F_BLT = 4;
  localparam int F_BLTU = 3,  F_JALR = 2,  F_COPY1 = 1, F_X    = 0;

  localparam logic [2:0] WB_MEM = 3'b100, WB_PC = 3'b010, WB_CSR = 3'b001;
  localparam logic [3:0] CSR_E = 4'b1000, CSR_W = 4'b0100, CSR_S = 4'b0010, CSR_C = 4'b0001;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [XLEN-1:0] immI, immS, immB, immJ, immU, immZ;
  logic [XLEN-1:0] rs1Val, rs2Val;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign immI = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign immS = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign immB = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign immJ = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign immU = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'h000};
  assign immZ = {{(XLEN-5){1'b0}}, in_inst[19:15]};

  // Newest producer wins; an EX load has no data yet and is left to the interlock.
  function automatic logic [XLEN-1:0] fwdSel(input logic [4:0] a, input logic [XLEN-1:0] rf);
    if (a == 5'd0)                                               return '0;
    else if (fwd_ex_we && !fwd_ex_is_load && fwd_ex_addr == a)   return fwd_ex_data;
    else if (fwd_mem_we && fwd_mem_addr == a)                    return fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_addr == a)                      return fwd_wb_data;
    else                                                         return rf;
  endfunction

  assign rs1Val = fwdSel(rs1_addr, rs1_rdata);
  assign rs2Val = fwdSel(rs2_addr, rs2_rdata);

  logic [18:0]     fun_d;
  logic [XLEN-1:0] op1_d, op2_d;
  logic            rdwen_d, memwe_d, memre_d, illegal_d, use1, use2;
  logic [2:0]      wbsel_d;
  logic [3:0]      csrcmd_d;
  logic [11:0]     csraddr_d;

  always_comb begin
    fun_d     = '0;
    op1_d     = '0;
    op2_d     = '0;
    rdwen_d   = 1'b0;
    memwe_d   = 1'b0;
    memre_d   = 1'b0;
    wbsel_d   = '0;
    csrcmd_d  = '0;
    csraddr_d = '0;
    illegal_d = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    case (opcode)
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          fun_d[F_ADD] = 1'b1; op1_d = rs1Val; op2_d = immI; use1 = 1'b1;
          memre_d = 1'b1; rdwen_d = 1'b1; wbsel_d = WB_MEM;
        end else illegal_d = 1'b1;
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          fun_d[F_ADD] = 1'b1; op1_d = rs1Val; op2_d = immS;
          use1 = 1'b1; use2 = 1'b1; memwe_d = 1'b1;
        end else illegal_d = 1'b1;
      end
      7'b0110011: begin
        op1_d = rs1Val; op2_d = rs2Val; use1 = 1'b1; use2 = 1'b1; rdwen_d = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: fun_d[F_ADD]  = 1'b1;
          10'b0100000_000: fun_d[F_SUB]  = 1'b1;
          10'b0000000_001: fun_d[F_SLL]  = 1'b1;
          10'b0000000_010: fun_d[F_SLT]  = 1'b1;
          10'b0000000_011: fun_d[F_SLTU] = 1'b1;
          10'b0000000_100: fun_d[F_XOR]  = 1'b1;
          10'b0000000_101: fun_d[F_SRL]  = 1'b1;
          10'b0100000_101: fun_d[F_SRA]  = 1'b1;
          10'b0000000_110: fun_d[F_OR]   = 1'b1;
          10'b0000000_111: fun_d[F_AND]  = 1'b1;
          default: begin illegal_d = 1'b1; rdwen_d = 1'b0; use1 = 1'b0; use2 = 1'b0; end
        endcase
      end
      7'b0010011: begin
        op1_d = rs1Val; op2_d = immI; use1 = 1'b1; rdwen_d = 1'b1;
        case (funct3)
          3'b000: fun_d[F_ADD]  = 1'b1;
          3'b010: fun_d[F_SLT]  = 1'b1;
          3'b011: fun_d[F_SLTU] = 1'b1;
          3'b100: fun_d[F_XOR]  = 1'b1;
          3'b110: fun_d[F_OR]   = 1'b1;
          3'b111: fun_d[F_AND]  = 1'b1;
          3'b001: if (funct7 == 7'b0000000) fun_d[F_SLL] = 1'b1;
                  else begin illegal_d = 1'b1; rdwen_d = 1'b0; use1 = 1'b0; end
          default: if (funct7 == 7'b0000000) fun_d[F_SRL] = 1'b1;
                   else if (funct7 == 7'b0100000) fun_d[F_SRA] = 1'b1;
                   else begin illegal_d = 1'b1; rdwen_d = 1'b0; use1 = 1'b0; end
        endcase
      end
      7'b1100011: begin
        op1_d = in_pc; op2_d = immB; use1 = 1'b1; use2 = 1'b1;
        case (funct3)
          3'b000: fun_d[F_BEQ]  = (rs1Val == rs2Val);
          3'b001: fun_d[F_BNE]  = (rs1Val != rs2Val);
          3'b100: fun_d[F_BLT]  = ($signed(rs1Val) <  $signed(rs2Val));
          3'b101: fun_d[F_BGE]  = ($signed(rs1Val) >= $signed(rs2Val));
          3'b110: fun_d[F_BLTU] = (rs1Val <  rs2Val);
          3'b111: fun_d[F_BGEU] = (rs1Val >= rs2Val);
          default: begin illegal_d = 1'b1; use1 = 1'b0; use2 = 1'b0; end
        endcase
      end
      7'b1101111: begin
        fun_d[F_ADD] = 1'b1; op1_d = in_pc; op2_d = immJ; rdwen_d = 1'b1; wbsel_d = WB_PC;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          fun_d[F_JALR] = 1'b1; op1_d = rs1Val; op2_d = immI; use1 = 1'b1;
          rdwen_d = 1'b1; wbsel_d = WB_PC;
        end else illegal_d = 1'b1;
      end
      7'b0110111: begin
        fun_d[F_ADD] = 1'b1; op2_d = immU; rdwen_d = 1'b1;
      end
      7'b0010111: begin
        fun_d[F_ADD] = 1'b1; op1_d = in_pc; op2_d = immU; rdwen_d = 1'b1;
      end
      7'b1110011: begin
        if (!CSR_EN) illegal_d = 1'b1;
        else if (funct3 == 3'b000) begin
          if (in_inst == 32'h0000_0073) begin
            fun_d[F_X] = 1'b1; csrcmd_d = CSR_E; csraddr_d = 12'h342;
          end else illegal_d = 1'b1;
        end else if (funct3 == 3'b100) illegal_d = 1'b1;
        else begin
          // The immediate forms carry a zero-extended uimm in the rs1 field.
          fun_d[F_COPY1] = 1'b1; rdwen_d = 1'b1; wbsel_d = WB_CSR; csraddr_d = in_inst[31:20];
          use1  = !funct3[2];
          op1_d = funct3[2] ? immZ : rs1Val;
          case (funct3[1:0])
            2'b01:   csrcmd_d = CSR_W;
            2'b10:   csrcmd_d = CSR_S;
            default: csrcmd_d = CSR_C;
          endcase
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic [0:0]      state_q;
  logic [1:0]      cnt_q;
  logic            valid_q, rdwen_q, memwe_q, memre_q, illegal_q;
  logic [XLEN-1:0] pc_q, op1_q, op2_q, rs2d_q;
  logic [4:0]      rd_q;
  logic [18:0]     fun_q;
  logic [2:0]      wbsel_q;
  logic [3:0]      csrcmd_q;
  logic [11:0]     csraddr_q;
  logic            adv, hazard;

  assign adv    = !valid_q || out_ready;
  assign hazard = in_valid && fwd_ex_we && fwd_ex_is_load && (fwd_ex_addr != 5'd0) &&
                  ((use1 && fwd_ex_addr == rs1_addr) || (use2 && fwd_ex_addr == rs2_addr));

  assign in_ready     = !rst && (flush || (adv && state_q == RUN && !hazard));
  assign hazard_stall = !rst && ((state_q == RUN && hazard) || state_q == STALL);

  // Bubbles only drop valid; payload registers load solely on a real issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;      cnt_q   <= '0;       valid_q   <= 1'b0;
      pc_q    <= '0;       op1_q   <= '0;       op2_q     <= '0;
      rs2d_q  <= '0;       rd_q    <= '0;       rdwen_q   <= 1'b0;
      fun_q   <= '0;       memwe_q <= 1'b0;     memre_q   <= 1'b0;
      wbsel_q <= '0;       csrcmd_q <= '0;      csraddr_q <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (adv) begin
      if (state_q == STALL) begin
        valid_q <= 1'b0;
        cnt_q   <= cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_q <= RUN;
      end else if (hazard) begin
        valid_q <= 1'b0;
        if (LOAD_USE_STALL > 1) begin
          state_q <= STALL;
          cnt_q   <= 2'(LOAD_USE_STALL - 1);
        end
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          pc_q    <= in_pc;    op1_q   <= op1_d;    op2_q     <= op2_d;
          rs2d_q  <= rs2Val;   rd_q    <= in_inst[11:7];
          rdwen_q <= rdwen_d;  fun_q   <= fun_d;    memwe_q   <= memwe_d;
          memre_q <= memre_d;  wbsel_q <= wbsel_d;  csrcmd_q  <= csrcmd_d;
          csraddr_q <= csraddr_d;                   illegal_q <= illegal_d;
        end
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_rs2_data = rs2d_q;
  assign out_rd       = rd_q;
  assign out_rd_wen   = rdwen_q;
  assign out_exe_fun  = fun_q;
  assign out_mem_we   = memwe_q;
  assign out_mem_re   = memre_q;
  assign out_wb_sel   = wbsel_q;
  assign out_csr_cmd  = csrcmd_q;
  assign out_csr_addr = csraddr_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a LOAD_USE_STALL=2/CSR_EN=1 instance and a
// LOAD_USE_STALL=1/CSR_EN=0 instance share stimulus; expectations are hand-computed.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst, rs1_rdata, rs2_rdata;
  logic        fwd_ex_we, fwd_ex_is_load, fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_ex_addr, fwd_mem_addr, fwd_wb_addr;
  logic [31:0] fwd_ex_data, fwd_mem_data, fwd_wb_data;

  logic        in_ready, out_valid, out_rd_wen, out_mem_we, out_mem_re, out_illegal, hazard_stall;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [31:0] out_pc, out_op1, out_op2, out_rs2_data;
  logic [18:0] out_exe_fun;
  logic [2:0]  out_wb_sel;
  logic [3:0]  out_csr_cmd;
  logic [11:0] out_csr_addr;

  logic        b_in_ready, b_out_valid, b_out_rd_wen, b_out_mem_we, b_out_mem_re, b_out_illegal, b_hazard_stall;
  logic [4:0]  b_rs1_addr, b_rs2_addr, b_out_rd;
  logic [31:0] b_out_pc, b_out_op1, b_out_op2, b_out_rs2_data;
  logic [18:0] b_out_exe_fun;
  logic [2:0]  b_out_wb_sel;
  logic [3:0]  b_out_csr_cmd;
  logic [11:0] b_out_csr_addr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .LOAD_USE_STALL(2), .CSR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_is_load(fwd_ex_is_load), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1),
    .out_op2(out_op2), .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_exe_fun(out_exe_fun), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_wb_sel(out_wb_sel),
    .out_csr_cmd(out_csr_cmd), .out_csr_addr(out_csr_addr), .out_illegal(out_illegal), .hazard_stall(hazard_stall)
  );

  id_stage_pipe #(.XLEN(32), .LOAD_USE_STALL(1), .CSR_EN(1'b0)) dutNoCsr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_is_load(fwd_ex_is_load), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_op1(b_out_op1),
    .out_op2(b_out_op2), .out_rs2_data(b_out_rs2_data), .out_rd(b_out_rd), .out_rd_wen(b_out_rd_wen),
    .out_exe_fun(b_out_exe_fun), .out_mem_we(b_out_mem_we), .out_mem_re(b_out_mem_re), .out_wb_sel(b_out_wb_sel),
    .out_csr_cmd(b_out_csr_cmd), .out_csr_addr(b_out_csr_addr), .out_illegal(b_out_illegal), .hazard_stall(b_hazard_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction and its regfile read data on the falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    rs1_rdata = r1;
    rs2_rdata = r2;
  endtask

  task automatic clearFwd();
    fwd_ex_we = 1'b0; fwd_ex_is_load = 1'b0; fwd_ex_addr = '0; fwd_ex_data = '0;
    fwd_mem_we = 1'b0; fwd_mem_addr = '0; fwd_mem_data = '0;
    fwd_wb_we = 1'b0; fwd_wb_addr = '0; fwd_wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; rs1_rdata = '0; rs2_rdata = '0;
    clearFwd();
    @(negedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("rst_fun", {13'd0, out_exe_fun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5
    applyStimulus(1'b1, 32'h100, 32'h0050_0093, 32'hAAAA, 32'hBBBB);
    #1 checkOutput("addi_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("addi_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("addi_pc", out_pc, 32'h100);
    checkOutput("addi_op1", out_op1, 32'd0);
    checkOutput("addi_op2", out_op2, 32'd5);
    checkOutput("addi_rd", {27'd0, out_rd}, 32'd1);
    checkOutput("addi_rdwen", {31'd0, out_rd_wen}, 32'd1);
    checkOutput("addi_fun", {13'd0, out_exe_fun}, 32'h4_0000);
    checkOutput("addi_illegal", {31'd0, out_illegal}, 32'd0);

    // add x3,x1,x2 with EX/MEM/WB all in play
    fwd_ex_we = 1'b1; fwd_ex_addr = 5'd1; fwd_ex_data = 32'h10;
    fwd_mem_we = 1'b1; fwd_mem_addr = 5'd1; fwd_mem_data = 32'h20;
    fwd_wb_we = 1'b1; fwd_wb_addr = 5'd2; fwd_wb_data = 32'h7;
    applyStimulus(1'b1, 32'h104, 32'h0020_81B3, 32'h0, 32'h55);
    tick();
    checkOutput("fwd_ex_op1", out_op1, 32'h10);
    checkOutput("fwd_wb_op2", out_op2, 32'h7);
    checkOutput("fwd_rs2_data", out_rs2_data, 32'h7);
    checkOutput("add_rd", {27'd0, out_rd}, 32'd3);
    fwd_ex_we = 1'b0;
    applyStimulus(1'b1, 32'h108, 32'h0020_81B3, 32'h0, 32'h55);
    tick();
    checkOutput("fwd_mem_op1", out_op1, 32'h20);
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
    applyStimulus(1'b1, 32'h10C, 32'h0020_81B3, 32'h33, 32'h55);
    tick();
    checkOutput("rf_op1", out_op1, 32'h33);
    checkOutput("rf_op2", out_op2, 32'h55);
    // add x3,x0,x2: a write to x0 must never forward
    fwd_ex_we = 1'b1; fwd_ex_addr = 5'd0; fwd_ex_data = 32'hDEAD;
    applyStimulus(1'b1, 32'h110, 32'h0020_01B3, 32'h99, 32'h55);
    tick();
    checkOutput("x0_op1", out_op1, 32'd0);
    clearFwd();

    // Load-use on x2: add x3,x2,x2
    fwd_ex_we = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd2; fwd_ex_data = 32'hBAD;
    applyStimulus(1'b1, 32'h114, 32'h0021_01B3, 32'h1, 32'h1);
    #1 checkOutput("lu_c1_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("lu_c1_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    checkOutput("lu_c1_bubble", {31'd0, out_valid}, 32'd0);
    checkOutput("lu1_c1_bubble", {31'd0, b_out_valid}, 32'd0);
    clearFwd();
    fwd_mem_we = 1'b1; fwd_mem_addr = 5'd2; fwd_mem_data = 32'h44;
    #1 checkOutput("lu_c2_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("lu_c2_hazard", {31'd0, hazard_stall}, 32'd1);
    checkOutput("lu1_c2_in_ready", {31'd0, b_in_ready}, 32'd1);
    tick();
    checkOutput("lu_c2_bubble", {31'd0, out_valid}, 32'd0);
    checkOutput("lu1_c2_issue", {31'd0, b_out_valid}, 32'd1);
    checkOutput("lu1_c2_op1", b_out_op1, 32'h44);
    @(negedge clk);
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b1; fwd_wb_addr = 5'd2; fwd_wb_data = 32'h44;
    #1 checkOutput("lu_c3_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("lu_c3_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    checkOutput("lu_c3_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("lu_c3_op1", out_op1, 32'h44);
    checkOutput("lu_c3_op2", out_op2, 32'h44);
    clearFwd();

    // Branches: beq/blt taken, beq/bltu not taken
    applyStimulus(1'b1, 32'h200, 32'h0020_8463, 32'd9, 32'd9);
    tick();
    checkOutput("beq_taken_fun", {13'd0, out_exe_fun}, 32'h100);
    checkOutput("beq_op1", out_op1, 32'h200);
    checkOutput("beq_op2", out_op2, 32'd8);
    checkOutput("beq_rdwen", {31'd0, out_rd_wen}, 32'd0);
    applyStimulus(1'b1, 32'h204, 32'h0020_8463, 32'd9, 32'd8);
    tick();
    checkOutput("beq_not_taken", {13'd0, out_exe_fun}, 32'd0);
    applyStimulus(1'b1, 32'h208, 32'h0020_C463, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("blt_signed", {13'd0, out_exe_fun}, 32'h10);
    applyStimulus(1'b1, 32'h20C, 32'h0020_E463, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("bltu_unsigned", {13'd0, out_exe_fun}, 32'd0);

    // Backpressure then flush with out_ready low
    applyStimulus(1'b1, 32'h300, 32'h0050_0093, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h304, 32'h0070_0093, 32'h0, 32'h0);
      out_ready = 1'b0;
      #1 checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_op2", out_op2, 32'd5);
      checkOutput("bp_pc", out_pc, 32'h300);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_release_op2", out_op2, 32'd7);
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b1;
    #1 checkOutput("flush_bp_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("flush_bp_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;

    // Flush in the middle of a stall
    fwd_ex_we = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd2;
    applyStimulus(1'b1, 32'h400, 32'h0021_01B3, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    clearFwd();
    flush = 1'b1;
    #1 checkOutput("flush_stall_hz", {31'd0, hazard_stall}, 32'd1);
    checkOutput("flush_stall_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("flush_stall_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 checkOutput("post_flush_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_flush_hz", {31'd0, hazard_stall}, 32'd0);
    tick();
    checkOutput("post_flush_valid", {31'd0, out_valid}, 32'd1);

    // CSR decode on both instances: csrrw x0,0x340,x5
    applyStimulus(1'b1, 32'h500, 32'h3402_9073, 32'h77, 32'h0);
    tick();
    checkOutput("csrrw_fun", {13'd0, out_exe_fun}, 32'h2);
    checkOutput("csrrw_cmd", {28'd0, out_csr_cmd}, 32'h4);
    checkOutput("csrrw_addr", {20'd0, out_csr_addr}, 32'h340);
    checkOutput("csrrw_wb", {29'd0, out_wb_sel}, 32'h1);
    checkOutput("csrrw_op1", out_op1, 32'h77);
    checkOutput("nocsr_illegal", {31'd0, b_out_illegal}, 32'd1);
    checkOutput("nocsr_rdwen", {31'd0, b_out_rd_wen}, 32'd0);
    checkOutput("nocsr_fun", {13'd0, b_out_exe_fun}, 32'd0);
    checkOutput("nocsr_cmd", {28'd0, b_out_csr_cmd}, 32'd0);
    applyStimulus(1'b1, 32'h504, 32'h0000_0073, 32'h0, 32'h0);
    tick();
    checkOutput("ecall_cmd", {28'd0, out_csr_cmd}, 32'h8);
    checkOutput("ecall_addr", {20'd0, out_csr_addr}, 32'h342);
    checkOutput("ecall_fun", {13'd0, out_exe_fun}, 32'h1);
    applyStimulus(1'b1, 32'h508, 32'hFFFF_FFFF, 32'h0, 32'h0);
    tick();
    checkOutput("bad_op_illegal", {31'd0, out_illegal}, 32'd1);
    checkOutput("bad_op_rdwen", {31'd0, out_rd_wen}, 32'd0);

    // sw x2,4(x1): store fields, then use it as held payload before a reset mid-stall
    applyStimulus(1'b1, 32'h600, 32'h0020_A223, 32'h1000, 32'h5A);
    tick();
    checkOutput("sw_mem_we", {31'd0, out_mem_we}, 32'd1);
    checkOutput("sw_op2", out_op2, 32'd4);
    checkOutput("sw_rs2_data", out_rs2_data, 32'h5A);
    fwd_ex_we = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd2;
    applyStimulus(1'b1, 32'h604, 32'h0021_01B3, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_hz", {31'd0, hazard_stall}, 32'd0);
    checkOutput("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mid_op2", out_op2, 32'd0);
    checkOutput("rst_mid_memwe", {31'd0, out_mem_we}, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Next-generation ID stage: RV32I plus Zicsr/ecall decode, operand select and branch compare, feeding a registered ID/EX pipeline register with valid/ready handshake.
- Sits between IF and EX; register file is external (combinational read ports).
- Adds over the current decoder:
  - parametrised multi-cycle load-use interlock (FSM plus counter);
  - three-level newest-first forwarding (EX/MEM/WB);
  - backpressure, flush and illegal-instruction flagging.

Parameters:
XLEN, 32, datapath width of pc/operands (only 32 supported for RV32 decode; immediates sign-extend to XLEN)
LOAD_USE_STALL, 1, bubbles inserted on load-use hazard (1..3)
CSR_EN, 1, 1 decodes csrrw/s/c(i) and ecall; 0 makes them illegal

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  IF instruction valid
in_ready  out  1  ID accepts instruction this cycle
in_pc  in  XLEN  instruction pc
in_inst  in  32  instruction word
rs1_addr, rs2_addr  out  5 each  = in_inst[19:15], in_inst[24:20]
rs1_rdata, rs2_rdata  in  XLEN each  regfile read data
fwd_ex_we / fwd_ex_is_load / fwd_ex_addr / fwd_ex_data  in  1/1/5/XLEN  EX-stage result
fwd_mem_we / fwd_mem_addr / fwd_mem_data  in  1/5/XLEN  MEM-stage result
fwd_wb_we / fwd_wb_addr / fwd_wb_data  in  1/5/XLEN  WB-stage result
flush  in  1  kill ID/EX contents and the current input
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc, out_op1, out_op2, out_rs2_data  out  XLEN each
out_rd  out  5;  out_rd_wen  out  1
out_exe_fun  out  19  one-hot {ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,BEQ,BNE,BGE,BGEU,BLT,BLTU,JALR,COPY1,X}; branch bits set only when taken
out_mem_we, out_mem_re  out  1 each
out_wb_sel  out  3  {MEM,PC,CSR}
out_csr_cmd  out  4  {E,W,S,C};  out_csr_addr  out  12  (0x342 for ecall)
out_illegal  out  1
hazard_stall  out  1  load-use interlock active

Behaviour:
- Reset (async, rst=1): out_valid=0, all out_* = 0, FSM=RUN, cnt=0, in_ready=0.
- adv = !out_valid || out_ready. When adv=0, ID/EX register and FSM hold; in_ready=0.
- Operand value per rs (rsN=0 → 0). Priority, first match wins:
  1. EX: fwd_ex_we && !fwd_ex_is_load && addr match;
  2. MEM: we && addr match;
  3. WB: we && addr match;
  4. regfile rdata.
- Operand select, immediates, rd_wen, wb_sel, csr encoding follow existing RV32I/Zicsr decode. Branch compares use forwarded values.
- Unrecognised opcode/funct, or CSR/ecall with CSR_EN=0: out_illegal=1, rd_wen=0, mem_we/re=0, exe_fun=0, csr_cmd=0.
- hazard = in_valid && fwd_ex_we && fwd_ex_is_load && fwd_ex_addr!=0 && (addr==rs1 used || addr==rs2 used). "Used" follows the operand-select tables.
- FSM RUN:
  - adv && hazard: load bubble (out_valid=0), in_ready=0. If LOAD_USE_STALL>1 → STALL with cnt=LOAD_USE_STALL-1.
  - adv && !hazard: in_ready=1; out_valid<=in_valid, fields latch decode.
- FSM STALL: in_ready=0, hazard_stall=1. Each adv cycle emits a bubble and decrements cnt; adv && cnt==1 → RUN.
- hazard_stall = (RUN && hazard) || STALL.
- flush (highest priority):
  - next cycle out_valid=0, FSM=RUN, cnt=0, independent of out_ready;
  - in_ready=1 and the input is dropped.
- Bubbles clear out_valid only; data fields are don't-care but must not glitch when out_valid=0 and adv=0.
- Latency 1 cycle in→out without hazard; throughput 1/cycle.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, op1=0, op2=5, rd=1, rd_wen=1, exe_fun=bit18 only.
- add x3,x1,x2 (0x002081B3); EX writes x1=0x10, MEM x1=0x20, WB x2=7, regfile x1=0 → op1=0x10, op2=7. Drop EX write → op1=0x20.
- Load-use: EX is_load rd=2; in add x3,x2,x2 (0x002101B3), LOAD_USE_STALL=2 → in_ready=0 for 2 cycles, two bubbles, hazard_stall=1; add issues cycle 3 with MEM/WB-forwarded x2.
- beq x1,x2 (0x00208463), x1=x2=9 → exe_fun BEQ bit set, op1=pc, op2=8. x2=8 → BEQ bit 0.
- Backpressure: out_ready=0 for 3 cycles with valid out → outputs stable, in_ready=0. flush mid-STALL → out_valid=0 next cycle, FSM RUN, in_ready=1.
- CSR_EN=0 with csrrw (0x34029073) → out_illegal=1, rd_wen=0. rst asserted mid-stall → all outputs 0 immediately.
